// File: rtl/io_unit_pkg.sv
// Shared constants and types for the memory-mapped IO unit: register offsets,
// control-word bit indices, FIFO sizing, STATUS layout and interrupt states.
package io_unit_pkg;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int M_IO_CS = 10;
  localparam int M_IO_RD = 11;
  localparam int M_IO_WR = 12;

  localparam int ST_IE      = 0;
  localparam int ST_UDF     = 1;
  localparam int ST_OVR     = 2;
  localparam int ST_TX_BUSY = 3;
  localparam int ST_CNT_LO  = 4;

  localparam int CTRL_IE  = 0;
  localparam int CTRL_CLR = 1;

  typedef enum logic [1:0] {IDLE, REQ, SERV} intr_state_e;
endpackage

// File: rtl/io_fifo.sv
// Receive FIFO: FIFO_DEPTH x DATA_W, wrapping pointers, head visible combinationally.
module io_fifo
  import io_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic              do_push, do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Storage is not reset; reset only invalidates it through the pointers/count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/io_unit.sv
// Memory-mapped IO unit: RX FIFO, single-word TX holding register, STATUS/CTRL.
// Interrupt FSM compiled in only when IO_UNIT_INTR_EN is defined.
module io_unit
  import io_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       EXMEM_ALU,
  input  logic [31:0]       pc4_mux,
  input  logic [15:0]       EXMEM_M,
  output logic [31:0]       io_out,
  output logic              intr,
  input  logic              intr_ack,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data
);
  logic              cs, rd_sel, wr_sel;
  logic [1:0]        sel;
  logic [DATA_W-1:0] head;
  logic              full, empty;
  logic [CNT_W-1:0]  count;
  logic              ovr, udf, ie;
  logic              push, pop;
  logic [31:0]       status;

  // rd and wr together is a write, so a read requires wr low.
  assign cs     = EXMEM_M[M_IO_CS];
  assign wr_sel = cs && EXMEM_M[M_IO_WR];
  assign rd_sel = cs && EXMEM_M[M_IO_RD] && !EXMEM_M[M_IO_WR];
  assign sel    = EXMEM_ALU[3:2];

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = rd_sel && (sel == REG_RXDATA) && !empty;

  io_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    status                             = '0;
    status[ST_CNT_LO +: CNT_W]         = count;
    status[ST_TX_BUSY]                 = out_valid;
    status[ST_OVR]                     = ovr;
    status[ST_UDF]                     = udf;
    status[ST_IE]                      = ie;
  end

  always_comb begin
    io_out = '0;
    if (rd_sel) begin
      case (sel)
        REG_RXDATA: io_out = empty ? '0 : head;
        REG_STATUS: io_out = status;
        default:    io_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      ovr       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (wr_sel && sel == REG_TXDATA) begin
        if (out_valid) ovr <= 1'b1;
        else begin
          out_data  <= pc4_mux;
          out_valid <= 1'b1;
        end
      end
      if (rd_sel && sel == REG_RXDATA && empty) udf <= 1'b1;
      if (wr_sel && sel == REG_CTRL && pc4_mux[CTRL_CLR]) begin
        ovr <= 1'b0;
        udf <= 1'b0;
      end
    end
  end

`ifdef IO_UNIT_INTR_EN
  intr_state_e state;

  always_ff @(posedge clk) begin
    if (rst) ie <= 1'b0;
    else if (wr_sel && sel == REG_CTRL) ie <= pc4_mux[CTRL_IE];
  end

  // intr is registered alongside the state so it is high exactly in REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      intr  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ie && count != '0) begin
          state <= REQ;
          intr  <= 1'b1;
        end
        REQ: if (!ie) begin
          state <= IDLE;
          intr  <= 1'b0;
        end else if (intr_ack) begin
          state <= SERV;
          intr  <= 1'b0;
        end
        SERV: if (count == '0) state <= IDLE;
        default: begin
          state <= IDLE;
          intr  <= 1'b0;
        end
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{EXMEM_ALU[31:4], EXMEM_ALU[1:0], EXMEM_M[15:13], EXMEM_M[9:0],
                       pc4_mux[31:2]};
`else
  assign ie   = 1'b0;
  assign intr = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{EXMEM_ALU[31:4], EXMEM_ALU[1:0], EXMEM_M[15:13], EXMEM_M[9:0],
                       pc4_mux[31:2], intr_ack};
`endif
endmodule

// File: tb/tb_io_unit.sv
// Self-checking bench for io_unit: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_io_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EXMEM_ALU, pc4_mux, in_data, io_out, out_data;
  logic [15:0] EXMEM_M;
  logic        intr, intr_ack, in_valid, in_ready, out_valid, out_ready;

  io_unit dut (
    .clk(clk), .rst(rst), .EXMEM_ALU(EXMEM_ALU), .pc4_mux(pc4_mux), .EXMEM_M(EXMEM_M),
    .io_out(io_out), .intr(intr), .intr_ack(intr_ack), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: FIFO as a queue, TX as a word + valid, intr as a 3-way mode.
  logic [31:0] mq[$];
  bit          m_ov, m_ovr, m_udf, m_ie;
  logic [31:0] m_od;
  int          m_st;  // 0 idle, 1 requesting, 2 being serviced

  function automatic logic [31:0] m_status();
    return {25'd0, 3'(mq.size()), m_ov, m_ovr, m_udf, m_ie};
  endfunction

  function automatic bit b_rd();
    return EXMEM_M[10] && EXMEM_M[11] && !EXMEM_M[12];
  endfunction
  function automatic bit b_wr();
    return EXMEM_M[10] && EXMEM_M[12];
  endfunction

  function automatic logic [31:0] m_io_out();
    if (!b_rd()) return 32'd0;
    case (EXMEM_ALU[3:2])
      2'd0:    return (mq.size() > 0) ? mq[0] : 32'd0;
      2'd1:    return m_status();
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    int n;
    bit nov;
    int nst;
    n = mq.size();
    if (rst) begin
      mq.delete(); m_ov = 0; m_od = 0; m_ovr = 0; m_udf = 0; m_ie = 0; m_st = 0;
      return;
    end
    nov = m_ov;
    if (m_ov && out_ready) nov = 0;
    if (b_wr() && EXMEM_ALU[3:2] == 2'd2) begin
      if (m_ov) m_ovr = 1;
      else begin m_od = pc4_mux; nov = 1; end
    end
    m_ov = nov;
    if (b_rd() && EXMEM_ALU[3:2] == 2'd0 && n == 0) m_udf = 1;
    nst = m_st;
`ifdef IO_UNIT_INTR_EN
    if (m_st == 0 && m_ie && n > 0) nst = 1;
    else if (m_st == 1 && !m_ie) nst = 0;
    else if (m_st == 1 && intr_ack) nst = 2;
    else if (m_st == 2 && n == 0) nst = 0;
`endif
    m_st = nst;
    if (b_wr() && EXMEM_ALU[3:2] == 2'd3) begin
`ifdef IO_UNIT_INTR_EN
      m_ie = pc4_mux[0];
`endif
      if (pc4_mux[1]) begin m_ovr = 0; m_udf = 0; end
    end
    if (b_rd() && EXMEM_ALU[3:2] == 2'd0 && n > 0) void'(mq.pop_front());
    if (in_valid && n < 4) mq.push_back(in_data);
  endtask

  task automatic cycle();
    @(negedge clk);
    check("io_out", io_out, m_io_out());
    check("in_ready", in_ready, 32'(mq.size() < 4));
    check("out_valid", out_valid, 32'(m_ov));
    check("out_data", out_data, m_od);
    check("intr", intr, 32'(m_st == 1));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input bit cs, input bit rd, input bit wr, input logic [1:0] sel,
                         input logic [31:0] data);
    EXMEM_M = '0;
    EXMEM_M[10] = cs; EXMEM_M[11] = rd; EXMEM_M[12] = wr;
    EXMEM_ALU = {28'd0, sel, 2'b00};
    pc4_mux = data;
  endtask

  task automatic idle();  set_bus(0, 0, 0, 2'd0, 32'd0); endtask
  task automatic rd_reg(input logic [1:0] s); set_bus(1, 1, 0, s, 32'd0); endtask
  task automatic wr_reg(input logic [1:0] s, input logic [31:0] d); set_bus(1, 0, 1, s, d); endtask

  initial begin
    logic [31:0] r;
    rst = 1; in_valid = 0; in_data = 0; out_ready = 0; intr_ack = 0; idle();
    m_ov = 0; m_od = 0; m_ovr = 0; m_udf = 0; m_ie = 0; m_st = 0;
    #1;
    cycle(); cycle();
    rst = 0;
    rd_reg(2'd1); #1;
    check("reset_status", io_out, 32'd0);
    check("reset_in_ready", in_ready, 32'd1);
    check("reset_out_valid", out_valid, 32'd0);
    cycle();

    // receive and read in order
    idle(); in_valid = 1; in_data = 32'hA5A5_0001; cycle();
    in_data = 32'hA5A5_0002; cycle();
    in_valid = 0; rd_reg(2'd1); #1;
    check("rx_count_2", io_out[6:4], 32'd2); cycle();
    rd_reg(2'd0); #1; check("rx_pop_first", io_out, 32'hA5A5_0001); cycle();
    #1; check("rx_pop_second", io_out, 32'hA5A5_0002); cycle();
    rd_reg(2'd1); #1; check("rx_count_0", io_out[6:4], 32'd0); cycle();

    // full boundary, underflow, sticky clear
    idle(); in_valid = 1;
    for (int i = 0; i < 5; i++) begin in_data = 32'h100 + i; cycle(); end
    in_valid = 0; #1;
    check("full_in_ready", in_ready, 32'd0);
    rd_reg(2'd1); #1; check("full_count", io_out[6:4], 32'd4); cycle();
    rd_reg(2'd0);
    for (int i = 0; i < 4; i++) begin #1; check("drain", io_out, 32'h100 + i); cycle(); end
    #1; check("empty_read", io_out, 32'd0); cycle();
    rd_reg(2'd1); #1; check("udf_set", io_out[1], 32'd1); cycle();
    wr_reg(2'd3, 32'h2); cycle();
    rd_reg(2'd1); #1; check("udf_clr", io_out[1], 32'd0); cycle();

    // transmit, overrun, handshake
    out_ready = 0; wr_reg(2'd2, 32'h1234); cycle();
    wr_reg(2'd2, 32'h5678); cycle();
    idle(); #1;
    check("tx_hold_data", out_data, 32'h1234);
    check("tx_valid", out_valid, 32'd1);
    rd_reg(2'd1); #1; check("ovr_set", io_out[2], 32'd1);
    out_ready = 1; cycle();
    check("tx_drop", out_valid, 32'd0);
    out_ready = 0; wr_reg(2'd3, 32'h2); cycle();

    // interrupt handshake
    wr_reg(2'd3, 32'h1); cycle();
    idle(); in_valid = 1; in_data = 32'hBEEF; cycle();
    in_valid = 0; cycle();
`ifdef IO_UNIT_INTR_EN
    check("intr_req", intr, 32'd1);
`else
    check("intr_tied", intr, 32'd0);
`endif
    intr_ack = 1; cycle(); intr_ack = 0;
    check("intr_ack_low", intr, 32'd0);
    rd_reg(2'd0); cycle();
    idle(); cycle(); cycle();
    check("intr_no_rereq", intr, 32'd0);

    // simultaneous push/pop at count 2
    in_valid = 1; in_data = 32'h11; cycle(); in_data = 32'h22; cycle();
    in_data = 32'h33; rd_reg(2'd0); cycle();
    in_valid = 0; rd_reg(2'd1); #1; check("pushpop_count", io_out[6:4], 32'd2); cycle();

    // reset while intr and out_valid are up (ie still 1, FIFO non-empty)
    wr_reg(2'd2, 32'hCAFE); cycle();
    idle(); cycle();
`ifdef IO_UNIT_INTR_EN
    check("pre_rst_intr", intr, 32'd1);
`endif
    check("pre_rst_ov", out_valid, 32'd1);
    rst = 1; cycle(); rst = 0;
    check("rst_intr", intr, 32'd0);
    check("rst_ov", out_valid, 32'd0);
    rd_reg(2'd1); #1; check("rst_status", io_out, 32'd0); cycle();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      EXMEM_M = 16'($urandom);
      EXMEM_M[10] = ($urandom_range(0, 3) != 0);
      EXMEM_ALU = $urandom;
      pc4_mux = $urandom;
      in_valid = r[0]; out_ready = r[1]; intr_ack = (r[3:2] == 2'b00);
      in_data = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
